// File: rtl/fpmult_pkg.sv
`default_nettype none
// Shared constants and types for the FP multiplier issue path.
package fpmult_pkg;

  localparam int FP_W         = 32;
  localparam int FP_XW        = 5;
  localparam int MULT_LATENCY = 4;

  localparam int EXC_ANY  = 4;
  localparam int EXC_ANAN = 3;
  localparam int EXC_BNAN = 2;
  localparam int EXC_AINF = 1;
  localparam int EXC_BINF = 0;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_id_e;

  typedef struct packed {
    logic     v;
    port_id_e id;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/fpmult_tag_pipe.sv
`default_nettype none
// LATENCY-deep {valid,id} shift register that tracks which requester owns
// each multiplier pipeline slot.
module fpmult_tag_pipe
  import fpmult_pkg::*;
#(
  parameter int LATENCY = MULT_LATENCY
) (
  input  logic clk,
  input  logic rst,
  input  tag_t in_tag,
  output tag_t tail,
  output logic any_valid
);

  tag_t stage [LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= in_tag;
      for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < LATENCY; i++) any_valid = any_valid | stage[i].v;
  end

  assign tail = stage[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/fpmult_issue_arbiter.sv
`default_nettype none
// Round-robin sharing of one pipelined FP multiplier between two requesters,
// with results steered back to the issuing port.
module fpmult_issue_arbiter
  import fpmult_pkg::*;
#(
  parameter int LATENCY = MULT_LATENCY,
  parameter int W       = FP_W,
  parameter int XW      = FP_XW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [W-1:0]  req0_a,
  input  logic [W-1:0]  req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [W-1:0]  req1_a,
  input  logic [W-1:0]  req1_b,
  output logic          mul_valid,
  output logic [W-1:0]  mul_a,
  output logic [W-1:0]  mul_b,
  input  logic [W-1:0]  mul_result,
  input  logic [XW-1:0] mul_flags,
  output logic          rsp0_valid,
  output logic [W-1:0]  rsp0_result,
  output logic [XW-1:0] rsp0_flags,
  output logic          rsp1_valid,
  output logic [W-1:0]  rsp1_result,
  output logic [XW-1:0] rsp1_flags,
  output logic          busy
);

  logic     grant0;
  logic     grant1;
  port_id_e last_grant;
  port_id_e issue_id;
  tag_t     in_tag;
  tag_t     tail;
  logic     tag_busy;

  // Under contention the port that did not win last time goes next.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | (last_grant == PORT1));
    grant1 = req1_valid & (~req0_valid | (last_grant == PORT0));
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_valid  <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      issue_id   <= PORT0;
      last_grant <= PORT1;
    end else begin
      mul_valid <= grant0 | grant1;
      if (grant0) begin
        mul_a      <= req0_a;
        mul_b      <= req0_b;
        issue_id   <= PORT0;
        last_grant <= PORT0;
      end else if (grant1) begin
        mul_a      <= req1_a;
        mul_b      <= req1_b;
        issue_id   <= PORT1;
        last_grant <= PORT1;
      end
    end
  end

  assign in_tag = '{v: mul_valid, id: issue_id};

  fpmult_tag_pipe #(
    .LATENCY (LATENCY)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_tag    (in_tag),
    .tail      (tail),
    .any_valid (tag_busy)
  );

  // The tail tag lines up with mul_result, so it alone decides the destination.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_flags  <= '0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_flags  <= '0;
    end else begin
      rsp0_valid <= tail.v & (tail.id == PORT0);
      rsp1_valid <= tail.v & (tail.id == PORT1);
      if (tail.v && tail.id == PORT0) begin
        rsp0_result <= mul_result;
        rsp0_flags  <= mul_flags;
      end
      if (tail.v && tail.id == PORT1) begin
        rsp1_result <= mul_result;
        rsp1_flags  <= mul_flags;
      end
    end
  end

  assign busy = mul_valid | tag_busy;

endmodule
`default_nettype wire

// File: tb/tb_fpmult_issue_arbiter.sv
`default_nettype none
// Scoreboard bench: a default-latency and a LATENCY=1 instance share the same
// stimulus; a reference arbiter/multiplier model predicts every response.
module tb_fpmult_issue_arbiter;
  import fpmult_pkg::*;

  localparam int NI = 2;

  typedef struct {
    logic [FP_W-1:0]  res;
    logic [FP_XW-1:0] flg;
    int               due;
  } exp_t;

  typedef struct {
    int               inst;
    int               port;
    int               due;
    logic [FP_W-1:0]  res;
    logic [FP_XW-1:0] flg;
    bit               chk_res;
  } dir_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic            req_valid [2];
  logic [FP_W-1:0] req_a [2];
  logic [FP_W-1:0] req_b [2];

  logic             rdy    [NI][2];
  logic             mvalid [NI];
  logic [FP_W-1:0]  ma     [NI];
  logic [FP_W-1:0]  mb     [NI];
  logic [FP_W-1:0]  mres   [NI];
  logic [FP_XW-1:0] mflg   [NI];
  logic             rv     [NI][2];
  logic [FP_W-1:0]  rres   [NI][2];
  logic [FP_XW-1:0] rflg   [NI][2];
  logic             bsy    [NI];

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t sbq [NI][2][$];
  dir_t dq [$];

  int              last_grant = 1;
  bit              pend [2];
  logic [FP_W-1:0] pa [2];
  logic [FP_W-1:0] pb [2];
  bit              prev_acc = 0;
  logic [FP_W-1:0] prev_a;
  logic [FP_W-1:0] prev_b;
  int              last_acc = -100;
  int              acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int i);
    return (i == 0) ? MULT_LATENCY : 1;
  endfunction

  function automatic void chk(input string name, input int inst,
                              input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL inst%0d %s: got %0h expected %0h (cycle %0d)", inst, name, act, exp, cyc);
  endfunction

  // Behavioural single-precision multiply: truncating, denormals treated as normals.
  function automatic logic [FP_XW+FP_W-1:0] fmul(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
    logic [FP_XW-1:0] f;
    logic [FP_W-1:0]  r;
    logic [47:0]      m;
    logic             s;
    int               e;
    s = a[31] ^ b[31];
    f = '0;
    f[EXC_ANAN] = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    f[EXC_BNAN] = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    f[EXC_AINF] = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    f[EXC_BINF] = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    f[EXC_ANY]  = |f[EXC_ANAN:EXC_BINF];
    if (f[EXC_ANAN] || f[EXC_BNAN]) r = 32'h7FC00000;
    else if (f[EXC_AINF] || f[EXC_BINF]) r = {s, 8'hFF, 23'h0};
    else begin
      m = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (m[47]) begin
        e = e + 1;
        m = m >> 1;
      end
      if (e >= 255) r = {s, 8'hFF, 23'h0};
      else if (e <= 0) r = {s, 31'h0};
      else r = {s, e[7:0], m[45:23]};
    end
    return {f, r};
  endfunction

  function automatic logic [FP_W-1:0] rand_op();
    case ($urandom_range(0, 9))
      0:       return 32'h7FC00000 | 32'($urandom_range(0, 255));
      1:       return (32'($urandom_range(0, 1)) << 31) | 32'h7F800000;
      default: return $urandom();
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int L = (g == 0) ? MULT_LATENCY : 1;
    logic [FP_XW+FP_W-1:0] mpipe [L];

    fpmult_issue_arbiter #(.LATENCY(L), .W(FP_W), .XW(FP_XW)) dut (
      .clk         (clk),
      .rst         (rst),
      .req0_valid  (req_valid[0]),
      .req0_ready  (rdy[g][0]),
      .req0_a      (req_a[0]),
      .req0_b      (req_b[0]),
      .req1_valid  (req_valid[1]),
      .req1_ready  (rdy[g][1]),
      .req1_a      (req_a[1]),
      .req1_b      (req_b[1]),
      .mul_valid   (mvalid[g]),
      .mul_a       (ma[g]),
      .mul_b       (mb[g]),
      .mul_result  (mres[g]),
      .mul_flags   (mflg[g]),
      .rsp0_valid  (rv[g][0]),
      .rsp0_result (rres[g][0]),
      .rsp0_flags  (rflg[g][0]),
      .rsp1_valid  (rv[g][1]),
      .rsp1_result (rres[g][1]),
      .rsp1_flags  (rflg[g][1]),
      .busy        (bsy[g])
    );

    // Multiplier model keeps computing every cycle, including through reset.
    always @(posedge clk) begin
      mpipe[0] <= fmul(ma[g], mb[g]);
      for (int j = 1; j < L; j++) mpipe[j] <= mpipe[j-1];
    end
    assign {mflg[g], mres[g]} = mpipe[L-1];
  end

  // One cycle of stimulus plus reference-model arbitration and issue checks.
  task automatic cycle_step(input bit want0, input bit want1);
    bit                    want [2];
    int                    g;
    logic [FP_XW+FP_W-1:0] m;
    want[0] = want0;
    want[1] = want1;
    for (int p = 0; p < 2; p++) begin
      if (!pend[p] && want[p]) begin
        pa[p]   = rand_op();
        pb[p]   = rand_op();
        pend[p] = 1'b1;
      end
      req_valid[p] = pend[p];
      req_a[p]     = pa[p];
      req_b[p]     = pb[p];
    end
    @(negedge clk);
    g = -1;
    if (pend[0] && pend[1]) g = 1 - last_grant;
    else if (pend[0]) g = 0;
    else if (pend[1]) g = 1;
    for (int i = 0; i < NI; i++) begin
      chk("req0_ready", i, rdy[i][0], g == 0);
      chk("req1_ready", i, rdy[i][1], g == 1);
      chk("mul_valid", i, mvalid[i], prev_acc);
      if (prev_acc) begin
        chk("mul_a", i, ma[i], prev_a);
        chk("mul_b", i, mb[i], prev_b);
      end
      chk("busy", i, bsy[i], (cyc > last_acc) && (cyc <= last_acc + lat(i) + 1));
    end
    prev_acc = (g >= 0);
    if (g >= 0) begin
      m = fmul(pa[g], pb[g]);
      for (int i = 0; i < NI; i++)
        sbq[i][g].push_back('{res: m[FP_W-1:0], flg: m[FP_XW+FP_W-1:FP_W], due: cyc + lat(i) + 2});
      last_grant = g;
      last_acc   = cyc;
      acc_cyc    = cyc;
      prev_a     = pa[g];
      prev_b     = pb[g];
      pend[g]    = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) cycle_step(1'b0, 1'b0);
  endtask

  task automatic issue(input int p, input logic [FP_W-1:0] a, input logic [FP_W-1:0] b, output int k);
    pa[p]   = a;
    pb[p]   = b;
    pend[p] = 1'b1;
    cycle_step(1'b0, 1'b0);
    k = acc_cyc;
  endtask

  task automatic push_dir(input int p, input int k, input logic [FP_W-1:0] res,
                          input logic [FP_XW-1:0] flg, input bit chk_res);
    for (int i = 0; i < NI; i++)
      dq.push_back('{inst: i, port: p, due: k + lat(i) + 2, res: res, flg: flg, chk_res: chk_res});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      pend[p]      = 1'b0;
      req_valid[p] = 1'b0;
      for (int i = 0; i < NI; i++) sbq[i][p].delete();
    end
    last_grant = 1;
    prev_acc   = 1'b0;
    last_acc   = -100;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_mul_valid", i, mvalid[i], 0);
      chk("rst_mul_a", i, ma[i], 0);
      chk("rst_mul_b", i, mb[i], 0);
      chk("rst_busy", i, bsy[i], 0);
      for (int p = 0; p < 2; p++) begin
        chk("rst_rsp_valid", i, rv[i][p], 0);
        chk("rst_rsp_result", i, rres[i][p], 0);
        chk("rst_rsp_flags", i, rflg[i][p], 0);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Response monitor: every presented result must match the head of its queue on time.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        for (int p = 0; p < 2; p++) begin
          if (rv[i][p]) begin
            if (sbq[i][p].size() == 0) chk($sformatf("rsp%0d_unexpected", p), i, rv[i][p], 0);
            else begin
              e = sbq[i][p].pop_front();
              chk($sformatf("rsp%0d_result", p), i, rres[i][p], e.res);
              chk($sformatf("rsp%0d_flags", p), i, rflg[i][p], e.flg);
              chk($sformatf("rsp%0d_cycle", p), i, cyc, e.due);
            end
          end else if (sbq[i][p].size() > 0 && sbq[i][p][0].due <= cyc) begin
            e = sbq[i][p].pop_front();
            chk($sformatf("rsp%0d_missing", p), i, rv[i][p], 1);
          end
        end
      end
    end
    for (int j = dq.size() - 1; j >= 0; j--) begin
      if (dq[j].due == cyc) begin
        chk("dir_valid", dq[j].inst, rv[dq[j].inst][dq[j].port], 1);
        chk("dir_other_valid", dq[j].inst, rv[dq[j].inst][1-dq[j].port], 0);
        chk("dir_flags", dq[j].inst, rflg[dq[j].inst][dq[j].port], dq[j].flg);
        if (dq[j].chk_res) chk("dir_result", dq[j].inst, rres[dq[j].inst][dq[j].port], dq[j].res);
        dq.delete(j);
      end
    end
  end

  initial begin
    int k;
    for (int p = 0; p < 2; p++) begin
      req_valid[p] = 1'b0;
      req_a[p]     = '0;
      req_b[p]     = '0;
      pend[p]      = 1'b0;
    end
    #1;
    do_reset();

    repeat (6) cycle_step(1'b1, 1'b1);
    drain(MULT_LATENCY + 4);

    issue(0, 32'h40000000, 32'h40400000, k);
    push_dir(0, k, 32'h40C00000, 5'h00, 1'b1);
    drain(MULT_LATENCY + 4);

    issue(1, 32'h7FC00000, 32'h3F800000, k);
    push_dir(1, k, 32'h0, 5'h18, 1'b0);
    drain(MULT_LATENCY + 4);

    repeat (3) cycle_step(1'b0, 1'b1);
    cycle_step(1'b1, 1'b0);
    drain(MULT_LATENCY + 4);

    repeat (400) cycle_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain(MULT_LATENCY + 4);

    repeat (3) cycle_step(1'b0, 1'b1);
    drain(2);
    do_reset();
    drain(MULT_LATENCY + 2);
    issue(0, 32'h40000000, 32'h40400000, k);
    push_dir(0, k, 32'h40C00000, 5'h00, 1'b1);
    drain(MULT_LATENCY + 4);

    for (int i = 0; i < NI; i++)
      for (int p = 0; p < 2; p++)
        chk($sformatf("sb%0d_empty", p), i, sbq[i][p].size(), 0);
    chk("dir_empty", 0, dq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
